// File: rtl/st_bytes_pkg.sv
// Framing characters, encoder stage type and special-byte test for the byte-stream link.
// The byte-to-packet decoder imports this package too, so both ends agree on the alphabet.
package st_bytes_pkg;

    localparam logic [7:0] SOP_CHAR  = 8'h7A;
    localparam logic [7:0] EOP_CHAR  = 8'h7B;
    localparam logic [7:0] CHAN_CHAR = 8'h7C;
    localparam logic [7:0] ESC_CHAR  = 8'h7D;

    typedef enum logic [2:0] {
        ST_START,
        ST_CHAN_CHAR,
        ST_CHAN_ESC,
        ST_CHAN_BYTE,
        ST_SOP,
        ST_EOP,
        ST_DATA_ESC,
        ST_DATA
    } stage_e;

    function automatic logic is_special(input logic [7:0] b);
        return (b == SOP_CHAR) || (b == EOP_CHAR) || (b == CHAN_CHAR) || (b == ESC_CHAR);
    endfunction

endpackage

// File: rtl/st_packets_to_bytes.sv
// Avalon-ST packet-to-byte encoder: turns each channelised packet beat into framing
// characters plus an escaped payload byte on a flat byte stream.
module st_packets_to_bytes
    import st_bytes_pkg::*;
#(
    parameter int unsigned EMIT_CHANNEL = 1,
    parameter logic [7:0]  ESC_XOR      = 8'h20
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       in_ready,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic [7:0] in_channel,
    input  logic       in_startofpacket,
    input  logic       in_endofpacket,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data
);

    // Handshake: a byte moves when out_valid & out_ready; a beat is consumed when
    // in_valid & in_ready, which only happens on the cycle its final byte moves.

    stage_e     stage_q, stage_d;
    stage_e     eff_stage;
    stage_e     next_stage;
    stage_e     data_first;
    stage_e     after_sop;
    stage_e     after_chan;
    stage_e     first_stage;
    logic [7:0] last_chan_q, last_chan_d;
    logic       chan_known_q, chan_known_d;
    logic       need_chan;
    logic       chan_special;
    logic       data_special;
    logic       xfer_out;
    logic       xfer_in;

    always_comb begin
        need_chan    = (EMIT_CHANNEL != 0) && (!chan_known_q || (in_channel != last_chan_q));
        chan_special = is_special(in_channel);
        data_special = is_special(in_data);

        data_first  = data_special ? ST_DATA_ESC : ST_DATA;
        after_sop   = in_endofpacket ? ST_EOP : data_first;
        after_chan  = in_startofpacket ? ST_SOP : after_sop;
        first_stage = need_chan ? ST_CHAN_CHAR : after_chan;

        // ST_START never emits; it stands for "first applicable stage of the head beat".
        eff_stage = (stage_q == ST_START) ? first_stage : stage_q;

        next_stage = ST_START;
        case (eff_stage)
            ST_CHAN_CHAR: next_stage = chan_special ? ST_CHAN_ESC : ST_CHAN_BYTE;
            ST_CHAN_ESC:  next_stage = ST_CHAN_BYTE;
            ST_CHAN_BYTE: next_stage = after_chan;
            ST_SOP:       next_stage = after_sop;
            ST_EOP:       next_stage = data_first;
            ST_DATA_ESC:  next_stage = ST_DATA;
            ST_DATA:      next_stage = ST_START;
            default:      next_stage = ST_START;
        endcase
    end

    always_comb begin
        out_data = in_data;
        case (eff_stage)
            ST_CHAN_CHAR: out_data = CHAN_CHAR;
            ST_CHAN_ESC:  out_data = ESC_CHAR;
            ST_CHAN_BYTE: out_data = chan_special ? (in_channel ^ ESC_XOR) : in_channel;
            ST_SOP:       out_data = SOP_CHAR;
            ST_EOP:       out_data = EOP_CHAR;
            ST_DATA_ESC:  out_data = ESC_CHAR;
            ST_DATA:      out_data = data_special ? (in_data ^ ESC_XOR) : in_data;
            default:      out_data = in_data;
        endcase
    end

    // Both handshake outputs are forced low while reset is asserted.
    always_comb begin
        out_valid = in_valid & reset_n;
        in_ready  = reset_n & out_ready & (eff_stage == ST_DATA);
        xfer_out  = out_valid & out_ready;
        xfer_in   = in_valid & in_ready;
    end

    always_comb begin
        stage_d      = stage_q;
        last_chan_d  = last_chan_q;
        chan_known_d = chan_known_q;
        if (xfer_out) begin
            stage_d = next_stage;
        end
        if (xfer_in) begin
            last_chan_d  = in_channel;
            chan_known_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q      <= ST_START;
            last_chan_q  <= 8'h00;
            chan_known_q <= 1'b0;
        end else begin
            stage_q      <= stage_d;
            last_chan_q  <= last_chan_d;
            chan_known_q <= chan_known_d;
        end
    end

endmodule

// File: tb/tb_st_packets_to_bytes.sv
// Self-checking bench for st_packets_to_bytes: scoreboarded byte encoding, backpressure,
// valid gaps, mid-sequence reset and a single-channel (no header) instance.
module tb_st_packets_to_bytes;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_ready, in_valid;
  logic [7:0] in_data, in_channel;
  logic       in_startofpacket, in_endofpacket;
  logic       out_ready, out_valid;
  logic [7:0] out_data;

  logic       nc_in_ready, nc_in_valid;
  logic [7:0] nc_in_data, nc_in_channel;
  logic       nc_out_ready, nc_out_valid;
  logic [7:0] nc_out_data;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  bit         mdl_known;
  logic [7:0] mdl_last;

  // clock / reset
  always #5 clk = ~clk;

  st_packets_to_bytes #(.EMIT_CHANNEL(1), .ESC_XOR(8'h20)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data), .in_channel(in_channel),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data)
  );

  st_packets_to_bytes #(.EMIT_CHANNEL(0), .ESC_XOR(8'h20)) u_dut_nc (
    .clk(clk), .reset_n(reset_n),
    .in_ready(nc_in_ready), .in_valid(nc_in_valid), .in_data(nc_in_data), .in_channel(nc_in_channel),
    .in_startofpacket(1'b0), .in_endofpacket(1'b0),
    .out_ready(nc_out_ready), .out_valid(nc_out_valid), .out_data(nc_out_data)
  );

  // source protocol: beat fields stay stable while a beat is pending
  bit         pend;
  logic [17:0] held;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0;
    end else begin
      if (pend && in_valid)
        assert ({in_channel, in_data, in_startofpacket, in_endofpacket} == held)
          else $error("protocol violation: beat fields changed before consumption");
      if (in_valid && in_ready) pend <= 1'b0;
      else if (in_valid) pend <= 1'b1;
      if (in_valid) held <= {in_channel, in_data, in_startofpacket, in_endofpacket};
    end
  end

  // scoreboard model
  function automatic bit tb_special(input logic [7:0] b);
    return (b >= 8'h7A) && (b <= 8'h7D);
  endfunction

  task automatic push_enc(input logic [7:0] b);
    if (tb_special(b)) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(b ^ 8'h20);
    end else begin
      exp_q.push_back(b);
    end
  endtask

  task automatic model_beat(input logic [7:0] ch, input bit sop, input bit eop,
                            input logic [7:0] d, input bit emit);
    if (emit && (!mdl_known || ch != mdl_last)) begin
      exp_q.push_back(8'h7C);
      push_enc(ch);
    end
    if (sop) exp_q.push_back(8'h7A);
    if (eop) exp_q.push_back(8'h7B);
    push_enc(d);
    if (emit) begin
      mdl_known = 1'b1;
      mdl_last  = ch;
    end
  endtask

  // driver: one beat on the main instance; stall_idx -2 means random out_ready
  task automatic drive_beat(input logic [7:0] ch, input bit sop, input bit eop, input logic [7:0] d,
                            input int stall_idx, input int stall_n, input int gap_idx, input int gap_n);
    int idx = 0;
    int stalls = 0;
    int gaps = 0;
    int cyc = 0;
    bit done = 0;
    logic exp_rdy;
    model_beat(ch, sop, eop, d, 1'b1);
    in_channel = ch; in_startofpacket = sop; in_endofpacket = eop; in_data = d;
    while (!done && cyc < 100) begin
      cyc++;
      if (idx == gap_idx && gaps < gap_n) begin
        in_valid = 1'b0;
        out_ready = 1'b1;
        gaps++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL gap_out_valid: got %b want 0", out_valid);
        end
      end else begin
        in_valid = 1'b1;
        if (stall_idx == -2) out_ready = 1'($urandom_range(0, 1));
        else out_ready = !(idx == stall_idx && stalls < stall_n);
        @(negedge clk);
        exp_rdy = out_ready && (exp_q.size() == 1);
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL out_valid: got %b want 1 (byte %0d)", out_valid, idx);
        end
        n_checks++;
        if (out_data !== exp_q[0]) begin
          n_fail++; $display("FAIL out_data: got %h want %h (byte %0d, ready %b)", out_data, exp_q[0], idx, out_ready);
        end
        n_checks++;
        if (in_ready !== exp_rdy) begin
          n_fail++; $display("FAIL in_ready: got %b want %b (byte %0d)", in_ready, exp_rdy, idx);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          idx++;
          if (exp_q.size() == 0) done = 1;
        end else begin
          stalls++;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL beat_timeout: %0d bytes left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b1; in_channel = 8'h00; in_data = 8'h41;
    in_startofpacket = 1'b1; in_endofpacket = 1'b1; out_ready = 1'b1;
    nc_in_valid = 1'b1; nc_in_channel = 8'h03; nc_in_data = 8'h11; nc_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL reset_outputs: valid %b ready %b want 0 0", out_valid, in_ready);
      end
      n_checks++;
      if (nc_out_valid !== 1'b0 || nc_in_ready !== 1'b0) begin
        n_fail++; $display("FAIL reset_outputs_nc: valid %b ready %b want 0 0", nc_out_valid, nc_in_ready);
      end
    end
    in_valid = 1'b0; nc_in_valid = 1'b0;
    reset_n = 1'b1;
    mdl_known = 1'b0; mdl_last = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_first_beat();
    drive_beat(8'h00, 1'b1, 1'b1, 8'h41, -1, 0, -1, 0);
  endtask

  task automatic test_same_channel();
    drive_beat(8'h00, 1'b1, 1'b0, 8'h7B, -1, 0, -1, 0);
    drive_beat(8'h00, 1'b0, 1'b1, 8'h10, -1, 0, -1, 0);
  endtask

  task automatic test_special_channel();
    drive_beat(8'h7D, 1'b1, 1'b0, 8'h7C, -1, 0, -1, 0);
  endtask

  task automatic test_reset_mid_sequence();
    in_channel = 8'h00; in_data = 8'h41; in_startofpacket = 1'b1; in_endofpacket = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_data !== 8'h7C || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_byte: got %b/%h want 1/7c", out_valid, out_data);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs: valid %b ready %b want 0 0", out_valid, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mdl_known = 1'b0; mdl_last = 8'h00;
    @(posedge clk); #1;
    // resend, holding out_ready low for 3 cycles on the 0x7A byte
    drive_beat(8'h00, 1'b1, 1'b1, 8'h41, 2, 3, -1, 0);
  endtask

  task automatic test_valid_gap();
    drive_beat(8'h7B, 1'b0, 1'b1, 8'h7D, -1, 0, 1, 2);
    drive_beat(8'h7B, 1'b1, 1'b0, 8'h55, -1, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] chans[4];
    logic [7:0] ch, d;
    chans[0] = 8'h00; chans[1] = 8'h01; chans[2] = 8'h7C; chans[3] = 8'h7D;
    for (int i = 0; i < 12; i++) begin
      ch = chans[$urandom_range(0, 3)];
      d  = ($urandom_range(0, 1) == 1) ? 8'(8'h7A + $urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      drive_beat(ch, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d,
                 -2, 0, ($urandom_range(0, 3) == 0) ? 1 : -1, 1);
    end
  endtask

  task automatic test_no_channel();
    logic [7:0] chs[4];
    logic [7:0] ds[4];
    int cyc = 0;
    chs[0] = 8'h03; chs[1] = 8'h05; chs[2] = 8'h05; chs[3] = 8'h03;
    ds[0]  = 8'h11; ds[1]  = 8'h22; ds[2]  = 8'h7A; ds[3]  = 8'h33;
    nc_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nc_in_channel = chs[i]; nc_in_data = ds[i]; nc_in_valid = 1'b1;
      model_beat(chs[i], 1'b0, 1'b0, ds[i], 1'b0);
      while (exp_q.size() != 0 && cyc < 20) begin
        @(negedge clk);
        n_checks++;
        if (nc_out_valid !== 1'b1 || nc_out_data !== exp_q[0]) begin
          n_fail++; $display("FAIL nc_out: got %b/%h want 1/%h", nc_out_valid, nc_out_data, exp_q[0]);
        end
        n_checks++;
        if (nc_in_ready !== (exp_q.size() == 1)) begin
          n_fail++; $display("FAIL nc_in_ready: got %b want %b", nc_in_ready, exp_q.size() == 1);
        end
        void'(exp_q.pop_front());
        cyc++;
        @(posedge clk); #1;
      end
      exp_q.delete();
    end
    nc_in_valid = 1'b0;
    n_checks++;
    if (cyc != 5) begin
      n_fail++; $display("FAIL nc_throughput: %0d cycles want 5", cyc);
    end
  endtask

  initial begin
    test_reset();
    test_first_beat();
    test_same_channel();
    test_special_channel();
    test_reset_mid_sequence();
    test_valid_gap();
    test_back_to_back();
    test_no_channel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
